// File: rtl/spi_cfg_ctrl.sv
// SPI write-only configuration controller: frames land in a staging bank
// that is committed atomically to the active bank driving the synth.
module spi_cfg_ctrl #(
    parameter int unsigned NREGS       = 16,
    parameter int unsigned ADDR_W      = $clog2(NREGS),
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               spi_clk,
    input  logic               spi_mosi,
    input  logic               spi_nss,
    input  logic               apply,
    output logic [NREGS*8-1:0] cfg_regs,
    output logic               cfg_update,
    output logic               pending,
    output logic               frame_err
);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, CHECK} state_t;

    localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NREGS - 1);

    logic [SYNC_STAGES-1:0]   sclk_sr, mosi_sr, nss_sr;
    logic                     sclk_s, mosi_s, nss_s;
    logic                     sclk_q, nss_q;
    logic                     sclk_rise, nss_rise, nss_fall;

    state_t                   state, state_nx;
    logic                     frame_clr, shift_en, check;

    logic [15:0]              frame;
    logic [4:0]               bit_cnt;
    logic                     frame_ok;
    logic [ADDR_W-1:0]        addr;
    logic                     data_wr, ctrl_wr, revert, commit;

    logic [NREGS-1:0][7:0]    staging;
    logic [NREGS-1:0][7:0]    active;

    assign sclk_s = sclk_sr[SYNC_STAGES-1];
    assign mosi_s = mosi_sr[SYNC_STAGES-1];
    assign nss_s  = nss_sr[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_q;
    assign nss_rise  = nss_s & ~nss_q;
    assign nss_fall  = ~nss_s & nss_q;

    // Synchronise SPI pins and keep one extra copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sr <= '0;
            mosi_sr <= '0;
            nss_sr  <= '0;
            sclk_q  <= 1'b0;
            nss_q   <= 1'b0;
        end else begin
            sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], spi_clk};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
            nss_sr  <= {nss_sr[SYNC_STAGES-2:0], spi_nss};
            sclk_q  <= sclk_s;
            nss_q   <= nss_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_IDLE;
        else        state <= state_nx;
    end

    // FSM next-state and frame control strobes
    always_comb begin
        state_nx  = state;
        frame_clr = 1'b0;
        shift_en  = 1'b0;
        check     = 1'b0;
        case (state)
            WAIT_IDLE: if (nss_s) state_nx = IDLE;
            IDLE: begin
                if (nss_fall) begin
                    frame_clr = 1'b1;
                    state_nx  = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = sclk_rise;
                if (nss_rise) state_nx = CHECK;
            end
            CHECK: begin
                check    = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = WAIT_IDLE;
        endcase
    end

    assign frame_ok = (bit_cnt == 5'd16) && (32'(frame[15:8]) < NREGS);
    assign addr     = frame[ADDR_W+7:8];
    assign data_wr  = check && frame_ok && (addr != CTRL_ADDR);
    assign ctrl_wr  = check && frame_ok && (addr == CTRL_ADDR);
    assign revert   = ctrl_wr && frame[1];
    assign commit   = !revert && ((apply && pending) || (ctrl_wr && frame[0]));

    // Shift register and saturating bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame   <= '0;
            bit_cnt <= '0;
        end else if (frame_clr) begin
            frame   <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            frame <= {frame[14:0], mosi_s};
            if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
        end
    end

    // Staging/active banks; commit samples staging before any same-cycle write.
    // The control slot is never written, so active reg NREGS-1 stays 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging    <= '0;
            active     <= '0;
            pending    <= 1'b0;
            cfg_update <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            cfg_update <= commit;
            frame_err  <= check && !frame_ok;
            if (commit) active <= staging;
            if (revert)       staging       <= active;
            else if (data_wr) staging[addr] <= frame[7:0];
            if (data_wr)               pending <= 1'b1;
            else if (commit || revert) pending <= 1'b0;
        end
    end

    assign cfg_regs = active;

endmodule

// File: tb/tb_spi_cfg_ctrl.sv
// Directed bench for spi_cfg_ctrl.
module tb_spi_cfg_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         spi_clk = 1'b0;
    logic         spi_mosi = 1'b0;
    logic         spi_nss = 1'b1;
    logic         apply = 1'b0;
    logic [127:0] cfg_regs;
    logic         cfg_update, pending, frame_err;

    int compared = 0;
    int mismatched = 0;

    logic [127:0] exp_regs = '0;
    logic [127:0] exp_stg = '0;
    logic [127:0] stg_now;

    int cyc = 0, upd_cnt = 0, err_cnt = 0, chg_cnt = 0;
    int upd_cyc = 0, pend_cyc = 0;
    logic [127:0] prev_regs = '0;
    logic pend_prev = 1'b0;

    spi_cfg_ctrl #(.NREGS(16), .ADDR_W(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_nss(spi_nss), .apply(apply), .cfg_regs(cfg_regs),
        .cfg_update(cfg_update), .pending(pending), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    assign stg_now = dut.staging;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cfg_update === 1'b1) begin
            upd_cnt = upd_cnt + 1;
            upd_cyc = cyc;
        end
        if (frame_err === 1'b1) err_cnt = err_cnt + 1;
        if (cfg_regs !== prev_regs) chg_cnt = chg_cnt + 1;
        prev_regs = cfg_regs;
        if (pending === 1'b1 && pend_prev !== 1'b1) pend_cyc = cyc;
        pend_prev = pending;
    end

    task automatic spi_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = v[i];
            #50 spi_clk = 1'b1;
            #50 spi_clk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] v, input int n);
        spi_nss = 1'b0;
        #100;
        spi_bits(v, n);
        #50 spi_nss = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    task automatic pulse_apply();
        @(negedge clk) apply = 1'b1;
        @(negedge clk) apply = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if ({cfg_regs, cfg_update, pending, frame_err} !== 131'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h/%b%b%b want all zero", cfg_regs, cfg_update, pending, frame_err);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_stage_apply();
        int u0;
        u0 = upd_cnt;
        send_frame(32'h0342, 16);
        exp_stg[8*3 +: 8] = 8'h42;
        compared++;
        if (stg_now !== exp_stg) begin
            mismatched++;
            $display("FAIL stage_write: got %h want %h", stg_now, exp_stg);
        end
        compared++;
        if (pending !== 1'b1 || cfg_regs !== exp_regs) begin
            mismatched++;
            $display("FAIL stage_no_commit: pending %b regs %h want 1 / %h", pending, cfg_regs, exp_regs);
        end
        pulse_apply();
        exp_regs = exp_stg;
        compared++;
        if (cfg_regs !== exp_regs || pending !== 1'b0) begin
            mismatched++;
            $display("FAIL apply_commit: regs %h pending %b want %h / 0", cfg_regs, pending, exp_regs);
        end
        compared++;
        if (upd_cnt - u0 !== 1) begin
            mismatched++;
            $display("FAIL apply_update_count: got %0d want 1", upd_cnt - u0);
        end
    endtask

    task automatic test_ctrl_commit();
        int u0, c0;
        send_frame(32'h0111, 16);
        send_frame(32'h0222, 16);
        exp_stg[8*1 +: 8] = 8'h11;
        exp_stg[8*2 +: 8] = 8'h22;
        compared++;
        if (cfg_regs !== exp_regs || pending !== 1'b1) begin
            mismatched++;
            $display("FAIL ctrl_pre: regs %h pending %b want %h / 1", cfg_regs, pending, exp_regs);
        end
        u0 = upd_cnt;
        c0 = chg_cnt;
        send_frame(32'h0F01, 16);
        exp_regs = exp_stg;
        compared++;
        if (cfg_regs !== exp_regs || pending !== 1'b0) begin
            mismatched++;
            $display("FAIL ctrl_commit: regs %h pending %b want %h / 0", cfg_regs, pending, exp_regs);
        end
        compared++;
        if (upd_cnt - u0 !== 1 || chg_cnt - c0 !== 1) begin
            mismatched++;
            $display("FAIL ctrl_atomic: updates %0d changes %0d want 1 / 1", upd_cnt - u0, chg_cnt - c0);
        end
    endtask

    task automatic test_errors();
        logic [31:0] fv [3];
        int          fn [3];
        int          e0;
        fv[0] = 32'h0377;  fn[0] = 15;
        fv[1] = 32'h10344; fn[1] = 17;
        fv[2] = 32'h2055;  fn[2] = 16;
        for (int k = 0; k < 3; k++) begin
            e0 = err_cnt;
            send_frame(fv[k], fn[k]);
            compared++;
            if (err_cnt - e0 !== 1) begin
                mismatched++;
                $display("FAIL err_pulse_%0d: got %0d pulses want 1", k, err_cnt - e0);
            end
            compared++;
            if (stg_now !== exp_stg || pending !== 1'b0) begin
                mismatched++;
                $display("FAIL err_nowrite_%0d: staging %h pending %b want %h / 0", k, stg_now, pending, exp_stg);
            end
        end
    endtask

    task automatic test_apply_held();
        int u0;
        u0 = upd_cnt;
        @(negedge clk) apply = 1'b1;
        send_frame(32'h0555, 16);
        repeat (10) @(negedge clk);
        apply = 1'b0;
        exp_stg[8*5 +: 8] = 8'h55;
        exp_regs = exp_stg;
        compared++;
        if (upd_cnt - u0 !== 1) begin
            mismatched++;
            $display("FAIL held_once: got %0d updates want 1", upd_cnt - u0);
        end
        compared++;
        if (upd_cyc - pend_cyc !== 1) begin
            mismatched++;
            $display("FAIL held_timing: update %0d cycles after write want 1", upd_cyc - pend_cyc);
        end
        compared++;
        if (cfg_regs !== exp_regs || pending !== 1'b0) begin
            mismatched++;
            $display("FAIL held_commit: regs %h pending %b want %h / 0", cfg_regs, pending, exp_regs);
        end
    endtask

    task automatic test_revert();
        int u0;
        send_frame(32'h0511, 16);
        compared++;
        if (pending !== 1'b1 || stg_now[8*5 +: 8] !== 8'h11) begin
            mismatched++;
            $display("FAIL revert_pre: pending %b staging5 %h want 1 / 11", pending, stg_now[8*5 +: 8]);
        end
        u0 = upd_cnt;
        send_frame(32'h0F02, 16);
        compared++;
        if (pending !== 1'b0 || stg_now !== exp_stg) begin
            mismatched++;
            $display("FAIL revert: pending %b staging %h want 0 / %h", pending, stg_now, exp_stg);
        end
        compared++;
        if (cfg_regs !== exp_regs || upd_cnt - u0 !== 0) begin
            mismatched++;
            $display("FAIL revert_active: regs %h updates %0d want %h / 0", cfg_regs, upd_cnt - u0, exp_regs);
        end
    endtask

    task automatic test_reset_midframe();
        int e0;
        spi_nss = 1'b0;
        #100;
        spi_bits(32'h03, 8);
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        e0 = err_cnt;
        spi_bits(32'h77, 8);
        #50 spi_nss = 1'b1;
        repeat (10) @(posedge clk);
        exp_regs = '0;
        exp_stg = '0;
        compared++;
        if (err_cnt - e0 !== 0 || pending !== 1'b0 || stg_now !== exp_stg) begin
            mismatched++;
            $display("FAIL midframe_drop: errs %0d pending %b staging %h want 0 / 0 / 0", err_cnt - e0, pending, stg_now);
        end
        send_frame(32'h0799, 16);
        exp_stg[8*7 +: 8] = 8'h99;
        pulse_apply();
        exp_regs = exp_stg;
        compared++;
        if (cfg_regs !== exp_regs || pending !== 1'b0) begin
            mismatched++;
            $display("FAIL midframe_next: regs %h pending %b want %h / 0", cfg_regs, pending, exp_regs);
        end
    endtask

    initial begin
        #3_000_000;
        mismatched++;
        $display("FAIL watchdog: bench exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stage_apply();
        test_ctrl_commit();
        test_errors();
        test_apply_held();
        test_revert();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
